// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared FSM state encoding and default width for serial_adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// Module  : fa_cell
// Brief   : Combinational 1-bit full adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial LSB-first adder/subtractor, one bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

  fa_cell u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_shift = w_s;
    end else begin : g_sum_wn
      assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_shift;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 spurious done", 64'(done8), 64'(0));
      end else begin
        e = q8.pop_front();
        check("w8 sum",        64'(sum8),  64'(e.sum));
        check("w8 cout",       64'(cout8), 64'(e.cout));
        check("w8 ovf",        64'(ovf8),  64'(e.ovf));
        check("w8 done cycle", 64'(cyc),   64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("w1 spurious done", 64'(done1), 64'(0));
      end else begin
        e = q1.pop_front();
        check("w1 sum",        64'(sum1),  64'(e.sum));
        check("w1 cout",       64'(cout1), 64'(e.cout));
        check("w1 ovf",        64'(ovf1),  64'(e.ovf));
        check("w1 done cycle", 64'(cyc),   64'(e.cyc));
      end
    end
  end

  // Issues one WIDTH=8 op at a negedge; returns at the negedge where done is due.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    check("w8 busy in run", 64'(busy8), 64'(1));
    repeat (8) @(negedge clk);
  endtask

  task automatic run1(input logic a, input logic b, input logic s,
                      input logic es, input logic ec, input logic eo);
    exp_t e;
    e.sum = {7'd0, es}; e.cout = ec; e.ovf = eo; e.cyc = cyc + 2;
    q1.push_back(e);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1 busy in run", 64'(busy1), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [1:0] t;
    logic ia, ib, is;

    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check("reset busy8", 64'(busy8), 64'(0));
    check("reset done8", 64'(done8), 64'(0));
    check("reset sum8",  64'(sum8),  64'(0));
    check("reset cout8", 64'(cout8), 64'(0));
    check("reset ovf8",  64'(ovf8),  64'(0));
    check("reset done1", 64'(done1), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Signed overflow on add, then results must hold through IDLE.
    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("hold sum",  64'(sum8),  64'(8'h96));
    check("hold ovf",  64'(ovf8),  64'(1));
    check("idle busy", 64'(busy8), 64'(0));
    check("idle done", 64'(done8), 64'(0));

    // Wraparound add, then back-to-back subtract launched from DONE.
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);

    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);

    // Reset in the middle of an operation: no expectation queued.
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy8), 64'(0));
    check("abort done", 64'(done8), 64'(0));
    check("abort sum",  64'(sum8),  64'(0));
    check("abort cout", 64'(cout8), 64'(0));
    check("abort ovf",  64'(ovf8),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
    @(negedge clk);

    // Start pulse during RUN must be ignored.
    e.sum = 8'h0B; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 9;
    q8.push_back(e);
    a8 = 8'h05; b8 = 8'h06; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);

    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    // WIDTH=1: all eight (a, b, sub) combinations, back-to-back.
    for (int i = 0; i < 8; i++) begin
      ia = i[0]; ib = i[1]; is = i[2];
      t = {1'b0, ia} + {1'b0, ib ^ is} + {1'b0, is};
      run1(ia, ib, is, t[0], t[1], is ^ t[1]);
    end
    repeat (3) @(negedge clk);

    check("w8 pending expectations", 64'(q8.size()), 64'(0));
    check("w1 pending expectations", 64'(q1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new operation; sampled on rising clk edges.
REQ-005 sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid sum/cout/ovf.
REQ-010 sum  output  WIDTH  result; held until the next accepted start.
REQ-011 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-013 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-014 start is accepted only when state is IDLE or DONE (busy=0); start while in RUN is ignored with no side effect.
REQ-015 On accepted start at edge k: latch a, b XOR {WIDTH{sub}}, carry <= sub, bit counter <= 0, sum <= 0; next state RUN.
REQ-016 RUN, each edge: one full-add of operand LSBs and the carry; result bit shifts into sum from the MSB side; operands shift right; carry updates; counter increments.
REQ-017 Processing is LSB-first, exactly one bit per cycle; WIDTH RUN cycles per operation.
REQ-018 At the edge that processes bit WIDTH-1 (edge k+WIDTH): state <= DONE; cout <= final carry; ovf <= carry-into-MSB XOR final carry.
REQ-019 done = 1 only in DONE state, for exactly one cycle (between edges k+WIDTH and k+WIDTH+1); busy = 1 only in RUN.
REQ-020 DONE with no start -> IDLE; DONE with start -> RUN (back-to-back operations, no idle gap).
REQ-021 sum, cout and ovf are held unchanged in DONE and IDLE until the next accepted start.
REQ-022 The counter is ceil(log2(WIDTH+1)) bits; WIDTH=1 completes in one RUN cycle.
REQ-023 Results are modulo 2^WIDTH; a and b changing after acceptance has no effect on the operation.

Reset
REQ-024 rst_n low immediately forces state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, counter=0.
REQ-025 Reset during RUN aborts the operation; no done pulse follows; the first start after rst_n rises is accepted normally.

Structure
REQ-026 Package adder_pkg holds the FSM state enum and the default WIDTH constant.
REQ-027 Bit arithmetic is one sub-module, fa_cell (combinational 1-bit full adder: a, b, cin -> s, cout), instantiated once in serial_adder.

Verification (WIDTH=8 unless noted)
REQ-028 add a=0x5A, b=0x3C -> done at start-edge+8; sum=0x96, cout=0, ovf=1.
REQ-029 add a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0; then sub a=0x10, b=0x20 back-to-back from DONE -> sum=0xF0, cout=0, ovf=0.
REQ-030 sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-031 start pulsed with a=0x01, b=0x01 at cycle 3 of RUN while an operation on 0x05+0x06 is running -> ignored; result sum=0x0B, single done pulse.
REQ-032 rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; subsequent 0x02+0x03 -> sum=0x05.
REQ-033 WIDTH=1, all 8 combinations of a, b, sub -> sum/cout match the 1-bit full-adder truth table, done one cycle after each start.
